// File: rtl/nmr_bstrm_seq_ctrl.sv
// NMR pulse-sequence controller: replays a table of pulse descriptors to a datapath
// through a START / DPATH_RDY handshake, for LOOP_CNT+1 passes over NUM_ENTRIES entries.
module nmr_bstrm_seq_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int MUX_WIDTH  = 16,
  parameter int DEPTH      = 16,
  parameter int AW         = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WR_EN,
  input  logic [AW-1:0]         WR_ADDR,
  input  logic [DATA_WIDTH-1:0] WR_LEN,
  input  logic                  WR_POL,
  input  logic [3:0]            WR_SEL,
  input  logic [MUX_WIDTH-2:0]  WR_MUXIN,
  input  logic [AW:0]           NUM_ENTRIES,
  input  logic [15:0]           LOOP_CNT,
  input  logic                  GO,
  input  logic                  ABORT,
  input  logic                  DPATH_RDY,
  output logic                  START,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  PLS_POL,
  output logic [3:0]            mux_sel,
  output logic [MUX_WIDTH-2:0]  mux_in,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [AW-1:0]         CUR_IDX
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_STRT, S_GUARD, S_WAIT, S_FIN
  } state_e;

  state_e         state_q, state_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [AW:0]    num_q, num_d;
  logic [15:0]    loops_q, loops_d;

  logic [DATA_WIDTH-1:0] tbl_len_q [DEPTH];
  logic                  tbl_pol_q [DEPTH];
  logic [3:0]            tbl_sel_q [DEPTH];
  logic [MUX_WIDTH-2:0]  tbl_mux_q [DEPTH];

  logic                  start_q, start_d;
  logic                  done_q, done_d;
  logic                  load_fields;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  pol_q;
  logic [3:0]            sel_q;
  logic [MUX_WIDTH-2:0]  mux_q;
  logic [AW-1:0]         cur_idx_q;

  logic num_ok;
  logic last_entry;

  assign num_ok     = (NUM_ENTRIES != '0) && (NUM_ENTRIES <= (AW+1)'(DEPTH));
  assign last_entry = ({1'b0, idx_q} == (num_q - 1'b1));

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      num_q   <= '0;
      loops_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      loops_q <= loops_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    num_d   = num_q;
    loops_d = loops_q;
    if (ABORT && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (GO) begin
            if (num_ok) begin
              num_d   = NUM_ENTRIES;
              loops_d = LOOP_CNT;
              idx_d   = '0;
              state_d = S_FETCH;
            end else begin
              state_d = S_FIN;
            end
          end
        end
        S_FETCH: if (DPATH_RDY) state_d = S_STRT;
        S_STRT:  state_d = S_GUARD;
        S_GUARD: state_d = S_WAIT;
        S_WAIT: begin
          if (DPATH_RDY) begin
            if (!last_entry) begin
              idx_d   = idx_q + 1'b1;
              state_d = S_FETCH;
            end else if (loops_q != '0) begin
              idx_d   = '0;
              loops_d = loops_q - 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_FIN;
            end
          end
        end
        S_FIN:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // START/DONE are registered, so they appear the cycle after STRT/FIN.
  always_comb begin
    start_d     = (state_q == S_STRT) && !ABORT;
    done_d      = (state_q == S_FIN) && !ABORT;
    load_fields = (state_q == S_FETCH);
  end

  // NOTE: the table is reset explicitly so the first sequence after reset never
  // issues undefined pulse descriptors; this forces flops rather than a RAM macro.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_len_q[i] <= '0;
        tbl_pol_q[i] <= 1'b0;
        tbl_sel_q[i] <= '0;
        tbl_mux_q[i] <= '0;
      end
    end else if (WR_EN && (state_q == S_IDLE)) begin
      tbl_len_q[WR_ADDR] <= WR_LEN;
      tbl_pol_q[WR_ADDR] <= WR_POL;
      tbl_sel_q[WR_ADDR] <= WR_SEL;
      tbl_mux_q[WR_ADDR] <= WR_MUXIN;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      data_q    <= '0;
      pol_q     <= 1'b0;
      sel_q     <= '0;
      mux_q     <= '0;
      cur_idx_q <= '0;
    end else begin
      start_q <= start_d;
      done_q  <= done_d;
      if (load_fields) begin
        data_q    <= tbl_len_q[idx_q];
        pol_q     <= tbl_pol_q[idx_q];
        sel_q     <= tbl_sel_q[idx_q];
        mux_q     <= tbl_mux_q[idx_q];
        cur_idx_q <= idx_q;
      end
    end
  end

  assign START   = start_q;
  assign DONE    = done_q;
  assign data    = data_q;
  assign PLS_POL = pol_q;
  assign mux_sel = sel_q;
  assign mux_in  = mux_q;
  assign CUR_IDX = cur_idx_q;
  assign BUSY    = (state_q != S_IDLE);

endmodule
